// File: rtl/matmul_seq_ctrl.sv
// Sequential NxN matrix-multiply controller: streams A and B in, runs one MAC per
// cycle over all N^3 products, then streams C out row-major.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; no handshakes accepted or offered
// LOAD    | accepting 2*N*N elements (A then B, row-major)
// COMPUTE | one multiply-accumulate per cycle, loop order i, j, k
// DRAIN   | presenting C elements until the last one is accepted
module matmul_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int N      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int LW = $clog2(2 * NN);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t            state;
    logic [LW-1:0]     ld_cnt;
    logic [IW-1:0]     i, j, k;
    logic [AW-1:0]     out_cnt;
    logic [DATA_W-1:0] acc;
    logic              done_r;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];
    logic [DATA_W-1:0] c_mem [NN];

    logic [AW-1:0]     a_idx, b_idx, c_idx;
    logic [DATA_W-1:0] prod, mac;
    logic              in_fire, k_last;

    // Product and sum are kept at DATA_W bits, so results wrap modulo 2^DATA_W.
    always_comb begin
        a_idx   = AW'(i * N + k);
        b_idx   = AW'(k * N + j);
        c_idx   = AW'(i * N + j);
        prod    = a_mem[a_idx] * b_mem[b_idx];
        mac     = (k == '0) ? prod : acc + prod;
        in_fire = (state == LOAD) && in_valid;
        k_last  = (k == IW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ld_cnt  <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            out_cnt <= '0;
            acc     <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        ld_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        if (ld_cnt == LW'(2 * NN - 1)) begin
                            state <= COMPUTE;
                            i     <= '0;
                            j     <= '0;
                            k     <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= mac;
                    if (!k_last) begin
                        k <= k + 1'b1;
                    end else begin
                        k <= '0;
                        if (j != IW'(N - 1)) begin
                            j <= j + 1'b1;
                        end else begin
                            j <= '0;
                            if (i != IW'(N - 1)) begin
                                i <= i + 1'b1;
                            end else begin
                                i     <= '0;
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_cnt == AW'(NN - 1)) begin
                            out_cnt <= '0;
                            state   <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and result storage carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (ld_cnt < LW'(NN))
                a_mem[AW'(ld_cnt)] <= in_data;
            else
                b_mem[AW'(ld_cnt - LW'(NN))] <= in_data;
        end
        if (state == COMPUTE && k_last)
            c_mem[c_idx] <= mac;
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (out_cnt == AW'(NN - 1));
    assign out_data  = (state == DRAIN) ? c_mem[out_cnt] : '0;
    assign done      = done_r;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl (N=3, DATA_W=32): expected C elements are queued
// when operands are chosen and popped as the controller drains them.
module tb_matmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [31:0] in_data;
    logic        busy, in_ready, out_valid, out_last, done;
    logic [31:0] out_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] elems [18];
    int          load_cyc, comp_cyc, drain_cyc;

    matmul_seq_ctrl #(.DATA_W(32), .N(3)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic push_model();
        logic [31:0] sum;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                sum = 32'd0;
                for (int m = 0; m < 3; m++)
                    sum = sum + elems[r*3+m] * elems[9+m*3+c];
                exp_q.push_back(sum);
            end
    endtask

    // One full operation; all drive and sample points are on the falling edge.
    task automatic run_op(input bit toggle_valid, input int stall_at, input bit poke_start,
                          input bit skip_start, input bit chain);
        int idx, guard, n, stall_left;
        bit ph;
        logic [31:0] e;
        if (!skip_start) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL load_entry: in_ready=%b busy=%b, want 1 1", in_ready, busy);
        end
        idx = 0; guard = 0; load_cyc = 0; ph = 1'b0;
        while (idx < 18 && guard < 200) begin
            in_valid = toggle_valid ? ph : 1'b1;
            ph = ~ph;
            in_data = elems[idx];
            if (in_valid && in_ready) idx++;
            load_cyc++; guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (idx < 18) begin
            bad++; $display("FAIL load_timeout: accepted=%0d want 18", idx);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL load_exit: in_ready=%b busy=%b, want 0 1", in_ready, busy);
        end
        comp_cyc = 0; guard = 0;
        while (!out_valid && guard < 200) begin
            start = (poke_start && comp_cyc == 10);
            if (comp_cyc == 5) begin
                total++;
                if (out_data !== 32'd0) begin
                    bad++; $display("FAIL compute_out_data: got %h want 0", out_data);
                end
            end
            comp_cyc++; guard++;
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL compute_timeout: out_valid never rose");
        end
        n = 0; guard = 0; stall_left = 3; drain_cyc = 0;
        while (n < 9 && guard < 200) begin
            if (n == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                total++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    bad++; $display("FAIL stall_hold: valid=%b data=%h", out_valid, out_data);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    total++;
                    if (out_data !== e || out_last !== logic'(n == 8)) begin
                        bad++; $display("FAIL c_elem[%0d]: got %h last=%b, want %h last=%b",
                                        n, out_data, out_last, e, n == 8);
                    end
                    n++;
                end
            end
            drain_cyc++; guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (n < 9) begin
            bad++; $display("FAIL drain_timeout: got %0d elements want 9", n);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0) begin
            bad++; $display("FAIL done_pulse: done=%b busy=%b out_valid=%b data=%h, want 1 0 0 0",
                            done, busy, out_valid, out_data);
        end
        if (chain) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || in_ready !== chain) begin
            bad++; $display("FAIL done_width: done=%b in_ready=%b, want 0 %b", done, in_ready, chain);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, in_ready, out_valid, out_last, done} !== 5'b0 || out_data !== 32'd0) begin
            bad++; $display("FAIL reset_outputs: busy=%b in_ready=%b out_valid=%b last=%b done=%b data=%h",
                            busy, in_ready, out_valid, out_last, done, out_data);
        end
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL idle_hold: busy=%b in_ready=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_identity();
        for (int x = 0; x < 9; x++) begin
            elems[x]   = (x % 4 == 0) ? 32'd1 : 32'd0;
            elems[9+x] = 32'(x + 1);
            exp_q.push_back(32'(x + 1));
        end
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
        total++;
        if (load_cyc != 18 || comp_cyc != 27 || drain_cyc != 9) begin
            bad++; $display("FAIL latency: load=%0d compute=%0d drain=%0d, want 18 27 9",
                            load_cyc, comp_cyc, drain_cyc);
        end
    endtask

    task automatic test_all_twos();
        for (int x = 0; x < 18; x++) elems[x] = 32'd2;
        for (int x = 0; x < 9; x++) exp_q.push_back(32'd12);
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_desc();
        logic [31:0] want [9];
        want = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        for (int x = 0; x < 9; x++) begin
            elems[x]   = 32'(x + 1);
            elems[9+x] = 32'(9 - x);
            exp_q.push_back(want[x]);
        end
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int x = 0; x < 9; x++) begin
            elems[x]   = (x < 3) ? 32'hFFFF_FFFF : 32'd0;
            elems[9+x] = 32'd2;
            exp_q.push_back((x < 3) ? 32'hFFFF_FFFA : 32'd0);
        end
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int x = 0; x < 18; x++) elems[x] = $urandom();
        push_model();
        run_op(1'b1, 4, 1'b0, 1'b0, 1'b0);
        total++;
        if (load_cyc < 35) begin
            bad++; $display("FAIL toggled_load: load=%0d cycles, want >= 35", load_cyc);
        end
        push_model();
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        for (int x = 0; x < 18; x++) elems[x] = $urandom_range(0, 1000);
        push_model();
        run_op(1'b0, -1, 1'b1, 1'b0, 1'b0);
        total++;
        if (comp_cyc != 27) begin
            bad++; $display("FAIL start_in_compute: compute=%0d cycles want 27", comp_cyc);
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin
                bad++; $display("FAIL no_second_run: busy=%b want 0", busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int x = 0; x < 18; x++) elems[x] = $urandom();
        push_model();
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b1);
        for (int x = 0; x < 18; x++) elems[x] = $urandom();
        push_model();
        run_op(1'b0, -1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1;
        repeat (18) begin
            in_data = $urandom();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_compute_busy: busy=%b want 1", busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, in_ready, out_valid, out_last, done} !== 5'b0 || out_data !== 32'd0) begin
            bad++; $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b done=%b data=%h, want all 0",
                            busy, in_ready, out_valid, done, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL after_reset_idle: busy=%b out_valid=%b", busy, out_valid);
        end
        for (int x = 0; x < 18; x++) elems[x] = $urandom();
        push_model();
        run_op(1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_twos();
        test_desc();
        test_wrap();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: %0d entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencing controller for the 3x3 matrix-multiply datapath. It accepts A and B as a valid/ready element stream and stores them in internal register files. It computes C = A x B by time-multiplexing a single multiply-accumulate unit over all N^3 products, then streams C out through valid/ready. It replaces the fully parallel 27-multiplier array when area matters more than latency.

Parameters:
DATA_W, 32, element width of A, B and C (unsigned; all arithmetic is modulo 2^DATA_W)
N, 3, matrix dimension; supported range 2..4

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle request to begin a new operation; sampled only in IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  input element valid
in_ready  out  1  controller can accept an input element
in_data  in  DATA_W  input element: A row-major, then B row-major (2*N*N elements)
out_valid  out  1  C element valid
out_ready  in  1  downstream accepts a C element
out_data  out  DATA_W  C element, row-major
out_last  out  1  high with the final C element (index N*N-1)
done  out  1  one-cycle pulse after the last C element is accepted

Behaviour:
- Reset: asynchronous and active-high. All state regs go to IDLE immediately; ld_cnt, i, j, k, out_cnt and acc clear. Reset is honoured mid-operation from any state with no partial output. Outputs under reset: busy=0, in_ready=0, out_valid=0, out_data=0, out_last=0, done=0. A/B/C storage is not reset; its contents are undefined until reloaded.
- Handshake: a transfer occurs on a rising edge where valid && ready. in_data and out_data are sampled or presented only on transfer cycles. out_valid, once asserted, holds and out_data stays stable until accepted.
- FSM states:
  - IDLE: in_ready=0, out_valid=0. start=1 moves to LOAD next cycle and clears ld_cnt.
  - LOAD: in_ready=1. On each transfer, element ld_cnt is written: index < N*N goes to A[idx/N][idx%N]; otherwise to B[(idx-N*N)/N][(idx-N*N)%N]. ld_cnt then increments. Cycles with in_valid=0 stall with no state change. Accepting element 2*N*N-1 moves to COMPUTE and deasserts in_ready in the same edge.
  - COMPUTE: exactly one MAC per cycle, N^3 cycles, no stalls. Loop order is i outer, j, k inner.
    - k=0: acc <= A[i][0]*B[0][j].
    - Otherwise: acc <= acc + A[i][k]*B[k][j].
    - When k=N-1: C[i][j] <= acc + A[i][k]*B[k][j] (the final sum), not the stale acc.
    - Product and sum are truncated to the low DATA_W bits, giving results identical to a combinational modulo-2^DATA_W reference.
    - After the (i,j,k)=(N-1,N-1,N-1) cycle, move to DRAIN.
  - DRAIN: out_valid=1, out_data=C[out_cnt/N][out_cnt%N], out_last=(out_cnt==N*N-1). Each transfer increments out_cnt. A transfer with out_last=1 moves to IDLE, pulses done for one cycle (the first IDLE cycle), and drops out_valid.
- Outside DRAIN, out_data=0.
- start asserted while busy=1 is ignored; it is not queued.
- in_valid in IDLE, COMPUTE or DRAIN is ignored (in_ready=0 there).
- start and done in the same cycle (IDLE): start is accepted and LOAD follows.
- Latency, N=3, with no stalls:
  - start edge to LOAD: 1 cycle.
  - LOAD: 18 cycles.
  - COMPUTE: 27 cycles.
  - First out_valid appears the cycle after the last MAC.
  - DRAIN: 9 cycles with out_ready held high.
  - done follows in the next cycle.

Test Plan:
- A = identity, B = {1..9} row-major, in_valid and out_ready held high -> out stream 1..9; out_last only on the 9th; done 1 cycle later; COMPUTE spans exactly 27 cycles.
- A = all 2, B = all 2 -> all nine C elements = 12.
- A = {1..9}, B = {9..1} -> C = {30,24,18,84,69,54,138,114,90}.
- A[0][*] = 0xFFFFFFFF, B = all 2, other A rows 0 -> C row 0 = 0xFFFFFFFA (wrapped), rows 1-2 = 0.
- in_valid toggled every other cycle; out_ready low for 3 cycles on element 4 -> out_data stable while stalled; same values as the unstalled run.
- start pulsed during COMPUTE -> ignored, no second run. rst asserted mid-COMPUTE -> busy=0 immediately. A following start plus full reload -> correct C.
